// File: rtl/ifetch_axi_rd_pkg.sv
// Shared definitions for the instruction-fetch AXI4 read responder.
// Contents: default widths, fixed AXI encodings, enable literals and the FSM state type.
package ifetch_axi_rd_pkg;

    localparam int unsigned ADDR_WIDTH_DEF  = 32;
    localparam int unsigned INSTR_WIDTH_DEF = 32;
    localparam int unsigned ID_WIDTH_DEF    = 4;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    localparam logic ENA_0 = 1'b0;
    localparam logic ENA_1 = 1'b1;

    typedef enum logic [1:0] {
        IFR_IDLE = 2'b00,
        IFR_ADDR = 2'b01,
        IFR_DATA = 2'b10,
        IFR_RESP = 2'b11
    } ifr_state_e;

endpackage

// File: rtl/ifetch_axi_rd_if.sv
// Bundle of the core fetch handshake and the AXI4 read-only instruction port.
// master: the fetch responder's view (drives instr/strobes and AR, accepts R).
// slave : the environment's view (core drives pc/fetch_pulse, memory drives arready and R).
interface ifetch_axi_rd_if
    import ifetch_axi_rd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int unsigned ID_WIDTH    = ID_WIDTH_DEF
);

    // Core side
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   fetch_pulse;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic                   instr_err;
    logic                   busy;

    // AXI4 AR channel
    logic [ID_WIDTH-1:0]    m_axi_arid;
    logic [ADDR_WIDTH-1:0]  m_axi_araddr;
    logic [7:0]             m_axi_arlen;
    logic [2:0]             m_axi_arsize;
    logic [1:0]             m_axi_arburst;
    logic                   m_axi_arvalid;
    logic                   m_axi_arready;

    // AXI4 R channel
    logic [ID_WIDTH-1:0]    m_axi_rid;
    logic [INSTR_WIDTH-1:0] m_axi_rdata;
    logic [1:0]             m_axi_rresp;
    logic                   m_axi_rlast;
    logic                   m_axi_rvalid;
    logic                   m_axi_rready;

    modport master (
        input  pc, fetch_pulse,
        output instr, instr_valid, instr_err, busy,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output pc, fetch_pulse,
        input  instr, instr_valid, instr_err, busy,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );

endinterface

// File: rtl/ifetch_axi_rd_axi_ar_chan.sv
// AR-channel register slice: captures an address and holds arvalid/araddr stable until the
// arready handshake. Reusable by any single-request read master.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   load_i      - capture addr_i this cycle
//   issue_i     - with load_i: raise arvalid (otherwise only the address is captured)
//   addr_i      - address to capture
//   arready_i   - AXI arready
//   arvalid_o   - AXI arvalid (registered)
//   araddr_o    - AXI araddr (registered)
module ifetch_axi_rd_axi_ar_chan
    import ifetch_axi_rd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic                  issue_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  arready_i,
    output logic                  arvalid_o,
    output logic [ADDR_WIDTH-1:0] araddr_o
);

    logic                  arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;

    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        if (load_i) begin
            araddr_d  = addr_i;
            arvalid_d = issue_i ? ENA_1 : ENA_0;
        end else if (arvalid_q && arready_i) begin
            arvalid_d = ENA_0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arvalid_q <= ENA_0;
            araddr_q  <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
        end
    end

    assign arvalid_o = arvalid_q;
    assign araddr_o  = araddr_q;

endmodule

// File: rtl/ifetch_axi_rd.sv
// Instruction-fetch responder: turns a single-cycle fetch request from the core into one
// single-beat AXI4 read and returns the word with a one-cycle instr_valid strobe.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   bus.master  - core fetch handshake (pc, fetch_pulse, instr, instr_valid, instr_err, busy)
//                 plus the AXI4 AR/R channels of the instruction port
// Only INSTR_WIDTH = 32 is supported (arsize is fixed to 4 bytes).
module ifetch_axi_rd
    import ifetch_axi_rd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int unsigned ID_WIDTH    = ID_WIDTH_DEF,
    parameter int unsigned FETCH_ID    = 0
) (
    input  logic            clk,
    input  logic            reset,
    ifetch_axi_rd_if.master bus
);

    localparam logic [ID_WIDTH-1:0] FetchId = ID_WIDTH'(FETCH_ID);

    ifr_state_e             state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   err_q, err_d;
    logic                   first_q, first_d;

    logic                   accept;
    logic                   misaligned;
    logic                   beat;
    logic                   beat_err;
    logic                   arvalid;
    logic [ADDR_WIDTH-1:0]  araddr;

    assign accept     = (state_q == IFR_IDLE) && bus.fetch_pulse;
    assign misaligned = (bus.pc[1:0] != 2'b00);
    assign beat       = (state_q == IFR_DATA) && bus.m_axi_rvalid;
    // A non-last beat means the slave ignored arlen=0; flag it but drain the burst.
    assign beat_err   = (bus.m_axi_rresp != RESP_OKAY) || (bus.m_axi_rid != FetchId) ||
                        !bus.m_axi_rlast;

    // Misaligned requests still latch araddr but never raise arvalid.
    ifetch_axi_rd_axi_ar_chan #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ar_chan (
        .clk       (clk),
        .reset     (reset),
        .load_i    (accept),
        .issue_i   (!misaligned),
        .addr_i    (bus.pc),
        .arready_i (bus.m_axi_arready),
        .arvalid_o (arvalid),
        .araddr_o  (araddr)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IFR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IFR_IDLE: if (accept) state_d = misaligned ? IFR_RESP : IFR_ADDR;
            IFR_ADDR: if (bus.m_axi_arready) state_d = IFR_DATA;
            IFR_DATA: if (beat && bus.m_axi_rlast) state_d = IFR_RESP;
            IFR_RESP: state_d = IFR_IDLE;
            default:  state_d = IFR_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.busy         = ENA_1;
        bus.instr_valid  = ENA_0;
        bus.instr_err    = ENA_0;
        bus.m_axi_rready = ENA_0;
        unique case (state_q)
            IFR_IDLE: bus.busy = ENA_0;
            IFR_ADDR: ;
            IFR_DATA: bus.m_axi_rready = ENA_1;
            IFR_RESP: begin
                bus.instr_valid = ENA_1;
                bus.instr_err   = err_q;
            end
            default: ;
        endcase
    end

    // Fetch datapath: instr capture and sticky error flag
    always_comb begin
        instr_d = instr_q;
        err_d   = err_q;
        first_d = first_q;
        if (accept) begin
            err_d   = misaligned;
            first_d = ENA_1;
            if (misaligned) begin
                instr_d = '0;
            end
        end else if (beat) begin
            first_d = ENA_0;
            if (first_q) begin
                instr_d = bus.m_axi_rdata;
            end
            if (beat_err) begin
                err_d = ENA_1;
            end
            // Errored fetches present instr = 0 in the strobe cycle.
            if (bus.m_axi_rlast && (err_q || beat_err)) begin
                instr_d = '0;
            end
        end else if (state_q == IFR_RESP) begin
            err_d = ENA_0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            err_q   <= ENA_0;
            first_q <= ENA_0;
        end else begin
            instr_q <= instr_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign bus.instr         = instr_q;
    assign bus.m_axi_arid    = FetchId;
    assign bus.m_axi_araddr  = araddr;
    assign bus.m_axi_arlen   = 8'd0;
    assign bus.m_axi_arsize  = SIZE_4B;
    assign bus.m_axi_arburst = BURST_INCR;
    assign bus.m_axi_arvalid = arvalid;

endmodule

// File: tb/tb_ifetch_axi_rd.sv
// Bench for ifetch_axi_rd: a vector table of single fetches against a configurable AXI
// responder, a scoreboard checked on every instr_valid strobe, and hand-written sequences for
// latency, requests while busy, and reset during a burst.
module tb_ifetch_axi_rd;
    import ifetch_axi_rd_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [3:0]  rid;
        int          nbeats;
        int          ar_delay;
        int          r_delay;
        logic [31:0] exp_instr;
        logic        exp_err;
        int          exp_ar;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ifetch_axi_rd_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .ID_WIDTH(4)) bus ();

    ifetch_axi_rd #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .ID_WIDTH    (4),
        .FETCH_ID    (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- AXI responder ----------------
    int          cfg_ar_delay = 0;
    int          cfg_r_delay  = 0;
    int          cfg_nbeats   = 1;
    logic [31:0] cfg_rdata    = 32'h0;
    logic [1:0]  cfg_rresp    = 2'b00;
    logic [3:0]  cfg_rid      = 4'h0;
    logic [31:0] exp_araddr   = 32'h0;
    bit          spurious_r   = 1'b0;
    int          ar_hs_cnt    = 0;
    int          last_ar_len  = 0;

    int          ar_cnt = 0;
    int          r_wait = 0;
    int          beats_left = 0;
    bit          r_pend = 1'b0;
    bit          ar_prev = 1'b0;
    bit          r_prev = 1'b0;
    logic [31:0] prev_araddr = 32'h0;

    // Inputs change on the falling edge; a handshake seen here completes at the next rise.
    always @(negedge clk) begin
        if (reset) begin
            bus.m_axi_arready = 1'b0;
            bus.m_axi_rvalid  = 1'b0;
            bus.m_axi_rlast   = 1'b0;
            bus.m_axi_rdata   = 32'h0;
            bus.m_axi_rresp   = 2'b00;
            bus.m_axi_rid     = 4'h0;
            ar_cnt = 0; r_wait = 0; beats_left = 0;
            r_pend = 1'b0; ar_prev = 1'b0; r_prev = 1'b0;
        end else begin
            if (r_prev) begin
                beats_left--;
                if (beats_left == 0) r_pend = 1'b0;
            end
            if (ar_prev) begin
                ar_hs_cnt++;
                last_ar_len = ar_cnt;
                r_pend      = 1'b1;
                r_wait      = 0;
                beats_left  = cfg_nbeats;
            end
            if (bus.m_axi_arvalid) begin
                if (ar_cnt == 0) check("araddr", bus.m_axi_araddr, exp_araddr);
                else check("araddr_stable", bus.m_axi_araddr, prev_araddr);
                prev_araddr = bus.m_axi_araddr;
                bus.m_axi_arready = (ar_cnt >= cfg_ar_delay);
                ar_cnt++;
            end else begin
                bus.m_axi_arready = 1'b0;
                ar_cnt = 0;
            end
            ar_prev = bus.m_axi_arvalid && bus.m_axi_arready;
            if (spurious_r) begin
                bus.m_axi_rvalid = 1'b1;
                bus.m_axi_rlast  = 1'b1;
                bus.m_axi_rdata  = 32'hBAD0_0BAD;
                bus.m_axi_rresp  = 2'b00;
                bus.m_axi_rid    = 4'h0;
            end else if (r_pend && r_wait >= cfg_r_delay) begin
                bus.m_axi_rvalid = 1'b1;
                bus.m_axi_rlast  = (beats_left == 1);
                bus.m_axi_rdata  = (beats_left == cfg_nbeats) ? cfg_rdata : ~cfg_rdata;
                bus.m_axi_rresp  = cfg_rresp;
                bus.m_axi_rid    = cfg_rid;
            end else begin
                bus.m_axi_rvalid = 1'b0;
                bus.m_axi_rlast  = 1'b0;
            end
            if (r_pend) r_wait++;
            r_prev = bus.m_axi_rvalid && bus.m_axi_rready;
        end
    end

    // ---------------- strobe monitor / scoreboard ----------------
    int   strobe_cnt = 0;
    bit   prev_valid = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.instr_valid) begin
                strobe_cnt++;
                check_bit("strobe_one_cycle", prev_valid, 1'b0);
                check_bit("busy_at_strobe", bus.busy, 1'b1);
                if (sb.size() == 0) begin
                    check_bit("unexpected_strobe", bus.instr_valid, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check("instr", bus.instr, mon_e.instr);
                    check_bit("instr_err", bus.instr_err, mon_e.err);
                end
            end else if (bus.instr_err) begin
                check_bit("err_without_valid", bus.instr_err, 1'b0);
            end
            prev_valid = bus.instr_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input logic [31:0] pc_v);
        @(negedge clk);
        bus.pc = pc_v;
        bus.fetch_pulse = 1'b1;
        @(negedge clk);
        bus.fetch_pulse = 1'b0;
        bus.pc = ~pc_v;  // must not reach araddr
    endtask

    task automatic wait_strobe(input int s0, input string name);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (strobe_cnt != s0) break;
        end
        check_bit({name, "_strobe_seen"}, (strobe_cnt != s0), 1'b1);
    endtask

    task automatic wait_valid_negedge(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.instr_valid) break;
            check_bit({name, "_busy_held"}, bus.busy, 1'b1);
        end
        check_bit({name, "_in_resp"}, bus.instr_valid, 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int s0 = strobe_cnt;
        int h0 = ar_hs_cnt;
        cfg_ar_delay = v.ar_delay;
        cfg_r_delay  = v.r_delay;
        cfg_nbeats   = v.nbeats;
        cfg_rdata    = v.rdata;
        cfg_rresp    = v.rresp;
        cfg_rid      = v.rid;
        exp_araddr   = v.pc;
        sb.push_back('{instr: v.exp_instr, err: v.exp_err});
        pulse(v.pc);
        wait_strobe(s0, $sformatf("vec%0d", idx));
        @(negedge clk);
        check_bit($sformatf("vec%0d_busy_after", idx), bus.busy, 1'b0);
        check($sformatf("vec%0d_ar_count", idx), ar_hs_cnt - h0, v.exp_ar);
        check($sformatf("vec%0d_strobes", idx), strobe_cnt - s0, 1);
        if (v.exp_ar != 0) check($sformatf("vec%0d_ar_hold", idx), last_ar_len, v.ar_delay + 1);
    endtask

    vec_t vecs[10];
    int   s0;
    int   h0;

    initial begin
        //           pc            rdata         rresp  rid  nb ard rd  exp_instr     err ar
        vecs[0] = '{32'h0000_0000, 32'h0000_0013, 2'b00, 4'h0, 1, 0, 0, 32'h0000_0013, 1'b0, 1};
        vecs[1] = '{32'h0000_0040, 32'h0000_0093, 2'b00, 4'h0, 1, 5, 3, 32'h0000_0093, 1'b0, 1};
        vecs[2] = '{32'h0000_0006, 32'h1111_1111, 2'b00, 4'h0, 1, 0, 0, 32'h0000_0000, 1'b1, 0};
        vecs[3] = '{32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 4'h0, 1, 0, 0, 32'h0000_0000, 1'b1, 1};
        vecs[4] = '{32'h0000_0004, 32'h0010_0093, 2'b00, 4'h0, 1, 0, 0, 32'h0010_0093, 1'b0, 1};
        vecs[5] = '{32'h0000_0010, 32'h0000_0513, 2'b00, 4'h3, 1, 1, 0, 32'h0000_0000, 1'b1, 1};
        vecs[6] = '{32'h0000_0020, 32'h0040_0113, 2'b00, 4'h0, 2, 0, 1, 32'h0000_0000, 1'b1, 1};
        vecs[7] = '{32'h0000_0003, 32'h2222_2222, 2'b00, 4'h0, 1, 0, 0, 32'h0000_0000, 1'b1, 0};
        vecs[8] = '{32'hFFFF_FFFC, 32'hCAFE_F00D, 2'b00, 4'h0, 1, 2, 0, 32'hCAFE_F00D, 1'b0, 1};
        vecs[9] = '{32'h0000_0200, 32'h0000_0073, 2'b11, 4'h0, 1, 0, 2, 32'h0000_0000, 1'b1, 1};

        reset = 1'b1;
        bus.pc = 32'h0;
        bus.fetch_pulse = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("rst_instr_valid", bus.instr_valid, 1'b0);
        check_bit("rst_instr_err", bus.instr_err, 1'b0);
        check_bit("rst_busy", bus.busy, 1'b0);
        check_bit("rst_arvalid", bus.m_axi_arvalid, 1'b0);
        check_bit("rst_rready", bus.m_axi_rready, 1'b0);
        check("rst_araddr", bus.m_axi_araddr, 32'h0);
        check("rst_instr", bus.instr, 32'h0);
        check("arlen", {24'h0, bus.m_axi_arlen}, 32'h0);
        check("arsize", {29'h0, bus.m_axi_arsize}, 32'h2);
        check("arburst", {30'h0, bus.m_axi_arburst}, 32'h1);
        check("arid", {28'h0, bus.m_axi_arid}, 32'h0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Minimum latency with both channels ready immediately.
        cfg_ar_delay = 0; cfg_r_delay = 0; cfg_nbeats = 1;
        cfg_rdata = 32'h0000_0013; cfg_rresp = 2'b00; cfg_rid = 4'h0;
        exp_araddr = 32'h0;
        sb.push_back('{instr: 32'h0000_0013, err: 1'b0});
        @(negedge clk);
        bus.pc = 32'h0; bus.fetch_pulse = 1'b1;              // cycle N
        @(negedge clk);
        bus.fetch_pulse = 1'b0;                              // N+1
        check_bit("lat_arvalid_n1", bus.m_axi_arvalid, 1'b1);
        check_bit("lat_busy_n1", bus.busy, 1'b1);
        @(negedge clk);                                      // N+2
        check_bit("lat_rready_n2", bus.m_axi_rready, 1'b1);
        check_bit("lat_arvalid_n2", bus.m_axi_arvalid, 1'b0);
        check_bit("lat_valid_n2", bus.instr_valid, 1'b0);
        @(negedge clk);                                      // N+3
        check_bit("lat_valid_n3", bus.instr_valid, 1'b1);
        @(negedge clk);                                      // N+4
        check_bit("lat_busy_n4", bus.busy, 1'b0);
        check_bit("lat_valid_n4", bus.instr_valid, 1'b0);
        check("lat_instr_hold", bus.instr, 32'h0000_0013);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // fetch_pulse during ADDR and during RESP is dropped.
        cfg_ar_delay = 3; cfg_r_delay = 1; cfg_nbeats = 1;
        cfg_rdata = 32'h0000_0513; cfg_rresp = 2'b00; cfg_rid = 4'h0;
        exp_araddr = 32'h0000_0040;
        s0 = strobe_cnt; h0 = ar_hs_cnt;
        sb.push_back('{instr: 32'h0000_0513, err: 1'b0});
        pulse(32'h0000_0040);
        bus.pc = 32'h0000_0080; bus.fetch_pulse = 1'b1;      // sampled in ADDR
        @(negedge clk);
        bus.fetch_pulse = 1'b0;
        wait_valid_negedge("busy_seq");
        bus.fetch_pulse = 1'b1;                              // sampled in RESP
        @(negedge clk);
        bus.fetch_pulse = 1'b0;
        check_bit("resp_pulse_ignored", bus.busy, 1'b0);
        repeat (10) @(negedge clk);
        check("busy_seq_ar_count", ar_hs_cnt - h0, 1);
        check("busy_seq_strobes", strobe_cnt - s0, 1);

        // fetch_pulse in the cycle right after RESP is accepted.
        cfg_ar_delay = 0; cfg_r_delay = 0;
        cfg_rdata = 32'h00A0_0093;
        exp_araddr = 32'h0000_0048;
        s0 = strobe_cnt; h0 = ar_hs_cnt;
        sb.push_back('{instr: 32'h00A0_0093, err: 1'b0});
        sb.push_back('{instr: 32'h00A0_0093, err: 1'b0});
        pulse(32'h0000_0048);
        wait_valid_negedge("post_resp");
        exp_araddr = 32'h0000_0044;
        @(negedge clk);
        bus.pc = 32'h0000_0044; bus.fetch_pulse = 1'b1;
        check_bit("post_resp_idle", bus.busy, 1'b0);
        @(negedge clk);
        bus.fetch_pulse = 1'b0;
        check_bit("post_resp_accepted", bus.busy, 1'b1);
        wait_strobe(s0 + 1, "post_resp_second");
        @(negedge clk);
        check("post_resp_ar_count", ar_hs_cnt - h0, 2);
        check("post_resp_strobes", strobe_cnt - s0, 2);

        // Asynchronous reset while waiting in DATA abandons the burst.
        cfg_r_delay = 8; cfg_rdata = 32'h1234_5678;
        exp_araddr = 32'h0000_0008;
        pulse(32'h0000_0008);
        for (int i = 0; i < 50 && !bus.m_axi_rready; i++) @(negedge clk);
        check_bit("rst_reached_data", bus.m_axi_rready, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_bit("arst_instr_valid", bus.instr_valid, 1'b0);
        check_bit("arst_instr_err", bus.instr_err, 1'b0);
        check_bit("arst_busy", bus.busy, 1'b0);
        check_bit("arst_arvalid", bus.m_axi_arvalid, 1'b0);
        check_bit("arst_rready", bus.m_axi_rready, 1'b0);
        check("arst_araddr", bus.m_axi_araddr, 32'h0);
        check("arst_instr", bus.instr, 32'h0);
        sb.delete();
        s0 = strobe_cnt;
        spurious_r = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_bit("spurious_rready", bus.m_axi_rready, 1'b0);
        end
        spurious_r = 1'b0;
        @(negedge clk);
        check("spurious_no_strobe", strobe_cnt - s0, 0);
        run_vec('{32'h0000_0008, 32'h0080_0113, 2'b00, 4'h0, 1, 0, 0,
                  32'h0080_0113, 1'b0, 1}, 10);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
